// File: rtl/knight_tour_seq.sv
// knight_tour_seq: steps through the solver's move store, splits each one-hot
// knight move into a vertical leg and a horizontal leg, and hands them to the
// motion consumer one at a time. It waits for the consumer's accept and
// completion handshakes before issuing the next leg. Outside a tour, host
// (UART) commands pass straight through to the consumer.
// Optional build macro: TOUR_ABORT_EN -- a host command with opcode 4'hF
// aborts a running tour.
module knight_tour_seq #(
    parameter int          NUM_MOVES  = 24,
    parameter logic [3:0]  OP_MOVE    = 4'h2,
    parameter logic [3:0]  OP_FANFARE = 4'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    input  logic [15:0] uart_cmd,
    input  logic        uart_cmd_rdy,
    output logic        clr_uart_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_busy,
    output logic        tour_err
);

    typedef enum logic [2:0] {IDLE, LOAD, VERT, WAIT_V, HORZ, WAIT_H, NEXT} state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] HD_NORTH  = 8'h00;
    localparam logic [7:0] HD_SOUTH  = 8'h7F;
    localparam logic [7:0] HD_WEST   = 8'h3F;
    localparam logic [7:0] HD_EAST   = 8'hBF;

    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic        tour_busy_q, tour_busy_d;
    logic        tour_err_q, tour_err_d;
    logic        tour_cmd_rdy_q, tour_cmd_rdy_d;
    logic [15:0] vert_leg_q, vert_leg_d;
    logic [15:0] horz_leg_q, horz_leg_d;

    logic [7:0]  v_head, h_head;
    logic [3:0]  v_sq, h_sq;
    logic        move_onehot;
    logic        abort;
    logic        in_idle;
    logic        on_horz;

`ifdef TOUR_ABORT_EN
    assign abort = tour_busy_q && uart_cmd_rdy && (uart_cmd[15:12] == 4'hF);
`else
    assign abort = 1'b0;
`endif

    // Decode the one-hot move into heading/distance for each leg.
    always_comb begin
        v_head = HD_NORTH;
        h_head = HD_EAST;
        v_sq   = 4'd0;
        h_sq   = 4'd0;
        unique case (move)
            8'h01:   begin v_head = HD_NORTH; v_sq = 4'd2; h_head = HD_WEST; h_sq = 4'd1; end
            8'h02:   begin v_head = HD_NORTH; v_sq = 4'd2; h_head = HD_EAST; h_sq = 4'd1; end
            8'h04:   begin v_head = HD_NORTH; v_sq = 4'd1; h_head = HD_WEST; h_sq = 4'd2; end
            8'h08:   begin v_head = HD_SOUTH; v_sq = 4'd1; h_head = HD_WEST; h_sq = 4'd2; end
            8'h10:   begin v_head = HD_SOUTH; v_sq = 4'd2; h_head = HD_WEST; h_sq = 4'd1; end
            8'h20:   begin v_head = HD_SOUTH; v_sq = 4'd2; h_head = HD_EAST; h_sq = 4'd1; end
            8'h40:   begin v_head = HD_SOUTH; v_sq = 4'd1; h_head = HD_EAST; h_sq = 4'd2; end
            8'h80:   begin v_head = HD_NORTH; v_sq = 4'd1; h_head = HD_EAST; h_sq = 4'd2; end
            default: begin v_head = HD_NORTH; v_sq = 4'd0; h_head = HD_EAST; h_sq = 4'd0; end
        endcase
        move_onehot = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
    end

    // Tour sequencing: next state, index, flags and latched legs.
    always_comb begin
        state_d        = state_q;
        mv_indx_d      = mv_indx_q;
        tour_busy_d    = tour_busy_q;
        tour_err_d     = tour_err_q;
        tour_cmd_rdy_d = tour_cmd_rdy_q;
        vert_leg_d     = vert_leg_q;
        horz_leg_d     = horz_leg_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    mv_indx_d   = 5'd0;
                    tour_err_d  = 1'b0;
                    tour_busy_d = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                // Latch now so the solver may move mv_indx's data afterward.
                vert_leg_d = {OP_MOVE, v_head, v_sq};
                horz_leg_d = {OP_FANFARE, h_head, h_sq};
                if (!move_onehot) begin
                    tour_err_d = 1'b1;
                    state_d    = NEXT;
                end else begin
                    tour_cmd_rdy_d = 1'b1;
                    state_d        = VERT;
                end
            end
            VERT: begin
                // Accept wins; a send_resp before/with accept is dropped.
                if (clr_cmd_rdy) begin
                    tour_cmd_rdy_d = 1'b0;
                    state_d        = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) begin
                    tour_cmd_rdy_d = 1'b1;
                    state_d        = HORZ;
                end
            end
            HORZ: begin
                if (clr_cmd_rdy) begin
                    tour_cmd_rdy_d = 1'b0;
                    state_d        = WAIT_H;
                end
            end
            WAIT_H: begin
                if (send_resp) state_d = NEXT;
            end
            NEXT: begin
                if (mv_indx_q == LAST_INDX) begin
                    tour_busy_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    mv_indx_d = mv_indx_q + 5'd1;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort abandons the tour wherever it is, even mid-leg.
        if (abort) begin
            tour_cmd_rdy_d = 1'b0;
            tour_busy_d    = 1'b0;
            state_d        = IDLE;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mv_indx_q      <= 5'd0;
            tour_busy_q    <= 1'b0;
            tour_err_q     <= 1'b0;
            tour_cmd_rdy_q <= 1'b0;
            vert_leg_q     <= 16'h0000;
            horz_leg_q     <= 16'h0000;
        end else begin
            state_q        <= state_d;
            mv_indx_q      <= mv_indx_d;
            tour_busy_q    <= tour_busy_d;
            tour_err_q     <= tour_err_d;
            tour_cmd_rdy_q <= tour_cmd_rdy_d;
            vert_leg_q     <= vert_leg_d;
            horz_leg_q     <= horz_leg_d;
        end
    end

    // Output muxing: host passthrough in IDLE (held off by a starting tour
    // so the host command stays pending), tour legs otherwise.
    always_comb begin
        in_idle = (state_q == IDLE);
        on_horz = (state_q == HORZ) || (state_q == WAIT_H);
        if (in_idle) begin
            cmd              = uart_cmd;
            cmd_rdy          = uart_cmd_rdy & ~start_tour;
            clr_uart_cmd_rdy = clr_cmd_rdy & ~start_tour;
        end else begin
            cmd              = on_horz ? horz_leg_q : vert_leg_q;
            cmd_rdy          = tour_cmd_rdy_q & ~abort;
            clr_uart_cmd_rdy = abort;
        end
        resp = (in_idle || (on_horz && mv_indx_q == LAST_INDX)) ? 8'h5A : 8'hA5;
    end

    assign mv_indx   = mv_indx_q;
    assign tour_busy = tour_busy_q;
    assign tour_err  = tour_err_q;

endmodule

// File: tb/tb_knight_tour_seq.sv
// Directed bench for knight_tour_seq: passthrough, single move handshakes,
// full tour, bad move, async reset mid-tour and host abort behaviour.
module tb_knight_tour_seq;

    logic        clk, rst, start_tour;
    logic [4:0]  mv_indx;
    logic [7:0]  move;
    logic [15:0] uart_cmd;
    logic        uart_cmd_rdy, clr_uart_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy, clr_cmd_rdy, send_resp;
    logic [7:0]  resp;
    logic        tour_busy, tour_err;

    logic [7:0]  mv_tab [0:31];
    logic [15:0] exp_cmd[$];
    int          exp_idx[$];
    int          total = 0;
    int          bad   = 0;
    bit          seen_clr = 0;
    bit          mon_en   = 0;

    knight_tour_seq dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .mv_indx(mv_indx),
        .move(move), .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy),
        .clr_uart_cmd_rdy(clr_uart_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tour_busy(tour_busy), .tour_err(tour_err)
    );

    // Solver move store model: combinational read.
    assign move = mv_tab[mv_indx];

    initial clk = 0;
    always #5 clk = ~clk;

    // Host command must never be acknowledged while a tour is running.
    always @(negedge clk) if (mon_en && tour_busy && clr_uart_cmd_rdy) seen_clr = 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void leg_exp(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
        case (m)
            8'h01: begin v = 16'h2002; h = 16'h33F1; end
            8'h02: begin v = 16'h2002; h = 16'h3BF1; end
            8'h04: begin v = 16'h2001; h = 16'h33F2; end
            8'h08: begin v = 16'h27F1; h = 16'h33F2; end
            8'h10: begin v = 16'h27F2; h = 16'h33F1; end
            8'h20: begin v = 16'h27F2; h = 16'h3BF1; end
            8'h40: begin v = 16'h27F1; h = 16'h3BF2; end
            default: begin v = 16'h2001; h = 16'h3BF2; end
        endcase
    endfunction

    task automatic fill_tab();
        for (int i = 0; i < 32; i++) mv_tab[i] = 8'h01 << (i % 8);
    endtask

    task automatic build_exp(input int last, input int skip);
        logic [15:0] v, h;
        exp_cmd.delete();
        exp_idx.delete();
        for (int i = 0; i <= last; i++) begin
            if (i != skip) begin
                leg_exp(mv_tab[i], v, h);
                exp_cmd.push_back(v); exp_idx.push_back(i);
                exp_cmd.push_back(h); exp_idx.push_back(i);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0; step();
    endtask

    task automatic start_pulse();
        start_tour = 1; step(); start_tour = 0;
    endtask

    // Consumer model: accept 3 cycles after cmd_rdy, complete 10 cycles later.
    task automatic drive_tour(input int nlegs);
        int n;
        logic [7:0] er;
        for (int k = 0; k < nlegs; k++) begin
            n = 0;
            while (cmd_rdy !== 1'b1 && n < 60) begin step(); n++; end
            total++;
            if (n >= 60) begin
                bad++; $display("FAIL leg%0d_wait: cmd_rdy never rose", k);
                return;
            end
            total++;
            if (cmd !== exp_cmd[k]) begin bad++; $display("FAIL leg%0d_cmd: got %h want %h", k, cmd, exp_cmd[k]); end
            total++;
            if (mv_indx !== 5'(exp_idx[k])) begin bad++; $display("FAIL leg%0d_indx: got %0d want %0d", k, mv_indx, exp_idx[k]); end
            er = (k % 2 == 1 && exp_idx[k] == 23) ? 8'h5A : 8'hA5;
            total++;
            if (resp !== er) begin bad++; $display("FAIL leg%0d_resp: got %h want %h", k, resp, er); end
            repeat (3) step();
            clr_cmd_rdy = 1; step(); clr_cmd_rdy = 0;
            total++;
            if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL leg%0d_drop: cmd_rdy got %b want 0", k, cmd_rdy); end
            repeat (10) step();
            send_resp = 1; step(); send_resp = 0;
            if (k % 2 == 0) begin
                total++;
                if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL leg%0d_horz_lat: cmd_rdy got %b want 1", k, cmd_rdy); end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; #3;
        total++; if (mv_indx !== 5'd0)   begin bad++; $display("FAIL rst_indx: got %0d want 0", mv_indx); end
        total++; if (tour_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", tour_busy); end
        total++; if (tour_err !== 1'b0)  begin bad++; $display("FAIL rst_err: got %b want 0", tour_err); end
        total++; if (cmd_rdy !== 1'b0)   begin bad++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
        total++; if (resp !== 8'h5A)     begin bad++; $display("FAIL rst_resp: got %h want 5a", resp); end
        step(); rst = 0; step();
    endtask

    task automatic test_passthrough();
        uart_cmd = 16'h2003; uart_cmd_rdy = 1; clr_cmd_rdy = 1; #1;
        total++; if (cmd !== 16'h2003)       begin bad++; $display("FAIL pass_cmd: got %h want 2003", cmd); end
        total++; if (cmd_rdy !== 1'b1)       begin bad++; $display("FAIL pass_rdy: got %b want 1", cmd_rdy); end
        total++; if (clr_uart_cmd_rdy !== 1) begin bad++; $display("FAIL pass_clr: got %b want 1", clr_uart_cmd_rdy); end
        step(); uart_cmd_rdy = 0; clr_cmd_rdy = 0; step();
    endtask

    task automatic test_single();
        fill_tab(); mv_tab[0] = 8'h02;
        start_pulse();
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL single_lat1: cmd_rdy got %b want 0", cmd_rdy); end
        step();
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL single_lat2: cmd_rdy got %b want 1", cmd_rdy); end
        total++; if (cmd !== 16'h2002) begin bad++; $display("FAIL single_vert: got %h want 2002", cmd); end
        send_resp = 1; step(); send_resp = 0;
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL single_early_resp: cmd_rdy got %b want 1", cmd_rdy); end
        clr_cmd_rdy = 1; send_resp = 1; step(); clr_cmd_rdy = 0; send_resp = 0;
        start_pulse();
        step(); step();
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL single_resp_dropped: cmd_rdy got %b want 0", cmd_rdy); end
        send_resp = 1; step(); send_resp = 0;
        total++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3BF1) begin bad++; $display("FAIL single_horz: got %b/%h want 1/3bf1", cmd_rdy, cmd); end
        total++; if (resp !== 8'hA5) begin bad++; $display("FAIL single_resp: got %h want a5", resp); end
        do_reset();
    endtask

    task automatic test_full_tour();
        int n;
        fill_tab(); build_exp(23, -1);
        uart_cmd = 16'h2001; uart_cmd_rdy = 1; start_tour = 1; #1;
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL full_start_wins: cmd_rdy got %b want 0", cmd_rdy); end
        step(); start_tour = 0;
        seen_clr = 0; mon_en = 1;
        total++; if (tour_busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", tour_busy); end
        drive_tour(48);
        n = 0;
        while (tour_busy === 1'b1 && n < 5) begin step(); n++; end
        mon_en = 0;
        total++; if (tour_busy !== 1'b0 || n > 2) begin bad++; $display("FAIL full_busy_fall: busy %b after %0d cycles want 0 within 2", tour_busy, n); end
        total++; if (cmd !== 16'h2001 || cmd_rdy !== 1'b1) begin bad++; $display("FAIL full_pending_host: got %h/%b want 2001/1", cmd, cmd_rdy); end
        total++; if (seen_clr !== 1'b0) begin bad++; $display("FAIL full_host_acked: got %b want 0", seen_clr); end
        uart_cmd_rdy = 0; step();
    endtask

    task automatic test_bad_move();
        fill_tab(); mv_tab[5] = 8'h03; build_exp(23, 5);
        start_pulse();
        drive_tour(46);
        repeat (3) step();
        total++; if (tour_err !== 1'b1)  begin bad++; $display("FAIL bad_err_set: got %b want 1", tour_err); end
        total++; if (tour_busy !== 1'b0) begin bad++; $display("FAIL bad_done: busy got %b want 0", tour_busy); end
        start_pulse();
        total++; if (tour_err !== 1'b0 || tour_busy !== 1'b1) begin bad++; $display("FAIL bad_err_clr: err/busy got %b/%b want 0/1", tour_err, tour_busy); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n;
        fill_tab(); build_exp(10, -1);
        start_pulse();
        drive_tour(21);
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin step(); n++; end
        clr_cmd_rdy = 1; step(); clr_cmd_rdy = 0;
        total++; if (mv_indx !== 5'd10 || tour_busy !== 1'b1) begin bad++; $display("FAIL rmid_pre: indx/busy got %0d/%b want 10/1", mv_indx, tour_busy); end
        #2 rst = 1; #1;
        total++; if (cmd_rdy !== 1'b0 || tour_busy !== 1'b0 || mv_indx !== 5'd0) begin
            bad++; $display("FAIL rmid_async: rdy/busy/indx got %b/%b/%0d want 0/0/0", cmd_rdy, tour_busy, mv_indx);
        end
        step(); rst = 0; step();
        uart_cmd = 16'h4321; uart_cmd_rdy = 1; clr_cmd_rdy = 1; #1;
        total++; if (cmd !== 16'h4321 || clr_uart_cmd_rdy !== 1'b1) begin bad++; $display("FAIL rmid_pass: got %h/%b want 4321/1", cmd, clr_uart_cmd_rdy); end
        step(); uart_cmd_rdy = 0; clr_cmd_rdy = 0; step();
    endtask

    task automatic test_abort();
        fill_tab(); build_exp(2, -1);
        start_pulse();
        drive_tour(6);
        step();
        uart_cmd = 16'hF000; uart_cmd_rdy = 1; #1;
`ifdef TOUR_ABORT_EN
        total++; if (clr_uart_cmd_rdy !== 1'b1) begin bad++; $display("FAIL abort_ack: got %b want 1", clr_uart_cmd_rdy); end
        step(); uart_cmd_rdy = 0; #1;
        total++; if (tour_busy !== 1'b0 || cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
            bad++; $display("FAIL abort_idle: busy/rdy/resp got %b/%b/%h want 0/0/5a", tour_busy, cmd_rdy, resp);
        end
`else
        total++; if (clr_uart_cmd_rdy !== 1'b0) begin bad++; $display("FAIL noabort_ack: got %b want 0", clr_uart_cmd_rdy); end
        repeat (4) step();
        total++; if (tour_busy !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== 16'h27F1 || clr_uart_cmd_rdy !== 1'b0) begin
            bad++; $display("FAIL noabort_run: busy/rdy/cmd/clr got %b/%b/%h/%b want 1/1/27f1/0", tour_busy, cmd_rdy, cmd, clr_uart_cmd_rdy);
        end
        uart_cmd_rdy = 0;
`endif
        do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start_tour = 0; uart_cmd = 16'h0; uart_cmd_rdy = 0;
        clr_cmd_rdy = 0; send_resp = 0; rst = 1;
        fill_tab();
        test_reset();
        test_passthrough();
        test_single();
        test_full_tour();
        test_bad_move();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
